// File: rtl/bpsk_pkg.sv
//------------------------------------------------------------------------------
// Module : bpsk_pkg
// Brief  : Shared types and defaults for the frame sync packer.
// Rev    : 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package bpsk_pkg;

  localparam int          DEFAULT_SYNC_WIDTH = 8;
  localparam logic [7:0]  DEFAULT_SYNC_WORD  = 8'hD3;

  typedef enum logic {HUNT = 1'b0, PAYLOAD = 1'b1} fsp_state_t;

  typedef struct packed {
    logic       first;
    logic [7:0] data;
  } fsp_entry_t;

endpackage

`default_nettype wire

// File: rtl/byte_fifo.sv
//------------------------------------------------------------------------------
// Module : byte_fifo
// Brief  : Small output FIFO with a registered head entry; push is accepted
//          when not full or when a pop happens in the same cycle.
// Rev    : 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module byte_fifo
  import bpsk_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  fsp_entry_t push_data,
  input  logic       pop,
  output fsp_entry_t head,
  output logic       empty,
  output logic       full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fsp_entry_t       mem [DEPTH];
  fsp_entry_t       head_next;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_next;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_after_pop;
  logic [CW-1:0]    count_next;
  logic             do_push;
  logic             do_pop;

  assign empty           = (count == '0);
  assign full            = (count == CW'(DEPTH));
  assign do_pop          = pop & ~empty;
  assign do_push         = push & (~full | do_pop);
  assign rd_next         = rd_ptr + AW'(do_pop);
  assign count_after_pop = count - CW'(do_pop);
  assign count_next      = count_after_pop + CW'(do_push);

  // The head register shows the entry the read pointer will sit on next;
  // when the queue drains to nothing but the incoming byte, forward it.
  always_comb begin
    head_next = '0;
    if (count_next != '0) begin
      if (count_after_pop == '0) head_next = push_data;
      else                       head_next = mem[rd_next];
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_next;
      count  <= count_next;
      head   <= head_next;
    end
  end

endmodule

`default_nettype wire

// File: rtl/frame_sync_packer.sv
//------------------------------------------------------------------------------
// Module : frame_sync_packer
// Brief  : Hunts a sync word in the demodulated bit stream, packs the
//          following payload MSB-first into bytes and queues them.
//          Optional macro SYNC_INVERT_EN also locks on the inverted sync word.
// Rev    : 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module frame_sync_packer
  import bpsk_pkg::*;
#(
  parameter int                    SYNC_WIDTH     = DEFAULT_SYNC_WIDTH,
  parameter logic [SYNC_WIDTH-1:0] SYNC_WORD      = SYNC_WIDTH'(DEFAULT_SYNC_WORD),
  parameter int                    FRAME_BYTES    = 4,
  parameter int                    FIFO_DEPTH     = 4,
  parameter int                    SYMBOL_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       bit_in,
  input  logic       bit_valid,
  output logic [7:0] byte_data,
  output logic       byte_first,
  output logic       byte_valid,
  input  logic       byte_ready,
  output logic       locked,
  output logic       frame_err,
  output logic       overflow,
  output logic       inverted
);

  localparam int BCW = $clog2(FRAME_BYTES + 1);
  localparam int TCW = $clog2(SYMBOL_TIMEOUT + 1);
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(FRAME_BYTES - 1);
  localparam logic [TCW-1:0] TO_LAST   = TCW'(SYMBOL_TIMEOUT - 1);

  fsp_state_t            state;
  logic [SYNC_WIDTH-1:0] sync_sr;
  logic [SYNC_WIDTH-1:0] sync_next;
  logic [7:0]            byte_sr;
  logic [7:0]            byte_next;
  logic [2:0]            bit_cnt;
  logic [BCW-1:0]        byte_cnt;
  logic [TCW-1:0]        timeout_cnt;
  logic                  match_true;
  logic                  match_inv;
  logic                  pay_bit;
  logic                  push;
  logic                  pop;
  logic                  fifo_empty;
  logic                  fifo_full;
  fsp_entry_t            push_entry;
  fsp_entry_t            head;

  assign sync_next  = {sync_sr[SYNC_WIDTH-2:0], bit_in};
  assign match_true = (sync_next == SYNC_WORD);
`ifdef SYNC_INVERT_EN
  assign match_inv  = (sync_next == ~SYNC_WORD);
`else
  assign match_inv  = 1'b0;
`endif

  assign pay_bit    = bit_in ^ inverted;
  assign byte_next  = {byte_sr[6:0], pay_bit};
  assign push       = (state == PAYLOAD) && bit_valid && (bit_cnt == 3'd7);
  assign push_entry = '{first: (byte_cnt == '0), data: byte_next};
  assign pop        = byte_valid & byte_ready;

  assign byte_valid = ~fifo_empty;
  assign byte_data  = head.data;
  assign byte_first = head.first;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= HUNT;
      sync_sr     <= '0;
      byte_sr     <= '0;
      bit_cnt     <= '0;
      byte_cnt    <= '0;
      timeout_cnt <= '0;
      locked      <= 1'b0;
      inverted    <= 1'b0;
      frame_err   <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overflow  <= push & fifo_full & ~pop;
      case (state)
        HUNT: begin
          timeout_cnt <= '0;
          if (bit_valid) begin
            sync_sr <= sync_next;
            if (match_true || match_inv) begin
              state    <= PAYLOAD;
              locked   <= 1'b1;
              inverted <= match_inv & ~match_true;
              bit_cnt  <= '0;
              byte_cnt <= '0;
            end
          end
        end
        PAYLOAD: begin
          if (bit_valid) begin
            // A strobe in the timeout cycle keeps the frame alive.
            timeout_cnt <= '0;
            byte_sr     <= byte_next;
            bit_cnt     <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              byte_cnt <= byte_cnt + BCW'(1);
              if (byte_cnt == LAST_BYTE) begin
                state    <= HUNT;
                locked   <= 1'b0;
                inverted <= 1'b0;
                sync_sr  <= '0;
                byte_cnt <= '0;
              end
            end
          end else if (timeout_cnt == TO_LAST) begin
            state       <= HUNT;
            locked      <= 1'b0;
            inverted    <= 1'b0;
            frame_err   <= 1'b1;
            timeout_cnt <= '0;
            bit_cnt     <= '0;
            byte_cnt    <= '0;
            byte_sr     <= '0;
            sync_sr     <= '0;
          end else begin
            timeout_cnt <= timeout_cnt + TCW'(1);
          end
        end
        default: state <= HUNT;
      endcase
    end
  end

  byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

endmodule

`default_nettype wire

// File: tb/tb_frame_sync_packer.sv
//------------------------------------------------------------------------------
// Module : tb_frame_sync_packer
// Brief  : Directed bench with a byte scoreboard for frame_sync_packer.
// Rev    : 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_frame_sync_packer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       bit_in = 1'b0;
  logic       bit_valid = 1'b0;
  logic [7:0] byte_data;
  logic       byte_first;
  logic       byte_valid;
  logic       byte_ready = 1'b1;
  logic       locked;
  logic       frame_err;
  logic       overflow;
  logic       inverted;

  int compared = 0;
  int mismatched = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  logic [8:0] sb [$];
  logic [8:0] exp_entry;

  frame_sync_packer dut (
    .clk        (clk),
    .reset      (reset),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .byte_data  (byte_data),
    .byte_first (byte_first),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .locked     (locked),
    .frame_err  (frame_err),
    .overflow   (overflow),
    .inverted   (inverted)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sample on the falling edge; the handshake seen here is what the DUT pops on the next rise.
  always @(negedge clk) begin
    if (reset) begin
      if (frame_err) fe_cnt++;
      if (overflow)  ov_cnt++;
      if (byte_valid && byte_ready) begin
        if (sb.size() == 0) begin
          compared++;
          mismatched++;
          $error("FAIL unexpected_byte observed=%0h expected=none", {byte_first, byte_data});
        end else begin
          exp_entry = sb.pop_front();
          check("byte", 32'({byte_first, byte_data}), 32'(exp_entry));
        end
      end
    end
  end

  task automatic send_bit(input logic b);
    bit_in = b;
    bit_valid = 1'b1;
    @(posedge clk);
    #1;
    bit_valid = 1'b0;
    bit_in = 1'b0;
  endtask

  task automatic send_bits(input logic [7:0] v, input int n);
    for (int i = 7; i > 7 - n; i--) send_bit(v[i]);
  endtask

  task automatic send_byte(input logic [7:0] v);
    send_bits(v, 8);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_byte(input logic first, input logic [7:0] v);
    sb.push_back({first, v});
  endtask

  task automatic drain(input string tag, input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) idle(1);
    check(tag, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    // Reset state
    #1;
    check("rst_valid", 32'(byte_valid), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_flags", 32'({frame_err, overflow, inverted}), 32'd0);
    check("rst_head", 32'({byte_first, byte_data}), 32'd0);
    idle(2);
    reset = 1'b1;
    idle(2);

    // 1: clean frame, first-byte latency and lock release
    send_byte(8'hD3);
    check("t1_locked", 32'(locked), 32'd1);
    check("t1_inv", 32'(inverted), 32'd0);
    expect_byte(1'b1, 8'h11);
    expect_byte(1'b0, 8'h22);
    expect_byte(1'b0, 8'h33);
    expect_byte(1'b0, 8'h44);
    send_byte(8'h11);
    check("t1_latency_valid", 32'(byte_valid), 32'd1);
    check("t1_latency_head", 32'({byte_first, byte_data}), 32'h111);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    check("t1_unlocked", 32'(locked), 32'd0);
    drain("t1_drain", 20);

    // 2: timeout mid-byte
    fe_cnt = 0;
    send_byte(8'hD3);
    expect_byte(1'b1, 8'hAB);
    send_byte(8'hAB);
    send_bits(8'hCD, 5);
    idle(60);
    check("t2_no_early_err", 32'(fe_cnt), 32'd0);
    check("t2_still_locked", 32'(locked), 32'd1);
    idle(10);
    check("t2_err_once", 32'(fe_cnt), 32'd1);
    check("t2_unlocked", 32'(locked), 32'd0);
    check("t2_no_partial", 32'(byte_valid), 32'd0);
    drain("t2_drain", 5);

    // 3: FIFO full, second frame dropped
    ov_cnt = 0;
    byte_ready = 1'b0;
    send_byte(8'hD3);
    expect_byte(1'b1, 8'hA1);
    expect_byte(1'b0, 8'hA2);
    expect_byte(1'b0, 8'hA3);
    expect_byte(1'b0, 8'hA4);
    send_byte(8'hA1);
    send_byte(8'hA2);
    send_byte(8'hA3);
    send_byte(8'hA4);
    send_byte(8'hD3);
    send_byte(8'hB1);
    send_byte(8'hB2);
    send_byte(8'hB3);
    send_byte(8'hB4);
    idle(2);
    check("t3_overflow_cnt", 32'(ov_cnt), 32'd4);
    check("t3_head_held", 32'({byte_valid, byte_first, byte_data}), 32'h3A1);
    byte_ready = 1'b1;
    drain("t3_drain", 20);
    check("t3_empty", 32'(byte_valid), 32'd0);

    // 4: partial sync matches in pre-sync noise
    send_byte(8'hD2);
    send_byte(8'h53);
    check("t4_no_false_lock", 32'(locked), 32'd0);
    send_byte(8'hD3);
    check("t4_locked", 32'(locked), 32'd1);
    expect_byte(1'b1, 8'h00);
    expect_byte(1'b0, 8'h00);
    expect_byte(1'b0, 8'h00);
    expect_byte(1'b0, 8'h01);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h01);
    drain("t4_drain", 20);

    // 5: inverted sync word
    send_byte(8'h2C);
`ifdef SYNC_INVERT_EN
    check("t5_locked", 32'(locked), 32'd1);
    check("t5_inverted", 32'(inverted), 32'd1);
    expect_byte(1'b1, 8'h11);
    expect_byte(1'b0, 8'h22);
    expect_byte(1'b0, 8'h33);
    expect_byte(1'b0, 8'h44);
`else
    check("t5_no_lock", 32'(locked), 32'd0);
    check("t5_inverted", 32'(inverted), 32'd0);
`endif
    send_byte(8'hEE);
    send_byte(8'hDD);
    send_byte(8'hCC);
    send_byte(8'hBB);
    check("t5_end_locked", 32'(locked), 32'd0);
    check("t5_end_inverted", 32'(inverted), 32'd0);
    drain("t5_drain", 20);
    idle(2);
    check("t5_no_bytes", 32'(byte_valid), 32'd0);

    // 6: asynchronous reset with bytes queued
    byte_ready = 1'b0;
    send_byte(8'hD3);
    send_byte(8'h55);
    send_byte(8'h66);
    send_bits(8'hF0, 3);
    check("t6_queued", 32'(byte_valid), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("t6_async_valid", 32'(byte_valid), 32'd0);
    check("t6_async_locked", 32'(locked), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    byte_ready = 1'b1;
    idle(1);
    send_byte(8'hD3);
    expect_byte(1'b1, 8'h12);
    expect_byte(1'b0, 8'h34);
    expect_byte(1'b0, 8'h56);
    expect_byte(1'b0, 8'h78);
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h56);
    send_byte(8'h78);
    drain("t6_drain", 20);
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
